asic_iopoc_seq: RTL



---
 rtl/asic_iopoc_pkg.sv | 17 +
 rtl/asic_iopoc_sync.sv | 26 ++
 rtl/asic_iopoc_seq.sv | 139 +++++++++++++
 3 files changed

// File: rtl/asic_iopoc_pkg.sv
// Shared definitions for the IO power-on-control sequencer.
//   state_t   : sequencer FSM states, 2-bit encoding.
//   NCTRL_DEF : default number of ring control bits (and sequence steps).
//   CW_DEF    : default width of the inter-step delay counter.
package asic_iopoc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UP    = 2'd1,
    ST_READY = 2'd2,
    ST_DOWN  = 2'd3
  } state_t;

  localparam int NCTRL_DEF = 8;
  localparam int CW_DEF    = 16;

endpackage

// File: rtl/asic_iopoc_sync.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk    in  : destination clock
//   nreset in  : asynchronous active-low reset, both flops clear to 0
//   d      in  : asynchronous input level
//   q      out : synchronized level, two clk edges after d settles
module asic_iopoc_sync (
  input  logic clk,
  input  logic nreset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/asic_iopoc_seq.sv
// Core-side power-on sequencer for the padring control ring. Once supply-good
// and the software enable are both present it raises ctrl one bit at a time
// (thermometer code) with a programmable inter-step delay, and lowers the bits
// in reverse order when either goes away.
// Optional feature: define ASIC_IOPOC_SEQ_SYNC_EN to pass pwrgood through a
// 2-flop synchronizer; otherwise pwrgood must already be synchronous to clk.
// Ports:
//   clk       in  : sequencer clock
//   nreset    in  : asynchronous active-low reset
//   pwrgood   in  : IO supply good
//   en        in  : power-up request (synchronous to clk)
//   delay     in  : cycles to wait between steps, sampled at each reload
//   ctrl      out : control ring drive, thermometer code
//   ready     out : all control bits set, sequence complete
//   busy      out : ramp-up or ramp-down in progress
//   dbg_state out : current FSM state (state_t encoding)
module asic_iopoc_seq
  import asic_iopoc_pkg::*;
#(
  parameter int NCTRL = NCTRL_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             pwrgood,
  input  logic             en,
  input  logic [CW-1:0]    delay,
  output logic [NCTRL-1:0] ctrl,
  output logic             ready,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int SW = $clog2(NCTRL + 1);
  localparam logic [SW-1:0] LAST = SW'(NCTRL - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [SW-1:0]    step, step_nxt;
  logic [NCTRL-1:0] ctrl_nxt;
  logic             ready_nxt, busy_nxt;
  logic             pwrgood_s;
  logic             go;
  logic             tick;

`ifdef ASIC_IOPOC_SEQ_SYNC_EN
  asic_iopoc_sync u_sync (
    .clk    (clk),
    .nreset (nreset),
    .d      (pwrgood),
    .q      (pwrgood_s)
  );
`else
  assign pwrgood_s = pwrgood;
`endif

  assign go        = pwrgood_s & en;
  assign tick      = (cnt == '0);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    step_nxt  = step;

    case (state)
      ST_IDLE: begin
        if (go) begin
          state_nxt = ST_UP;
          cnt_nxt   = delay;
          step_nxt  = '0;
        end
      end

      ST_UP: begin
        // Abort wins over a step due on the same edge.
        if (!go) begin
          state_nxt = ST_DOWN;
          cnt_nxt   = delay;
        end else if (!tick) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          step_nxt = step + SW'(1);
          cnt_nxt  = delay;
          if (step == LAST) state_nxt = ST_READY;
        end
      end

      ST_READY: begin
        if (!go) begin
          state_nxt = ST_DOWN;
          cnt_nxt   = delay;
        end
      end

      ST_DOWN: begin
        // Never aborted. An abort at step 0 has nothing to lower and simply
        // returns to IDLE once its delay expires.
        if (!tick) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          cnt_nxt = delay;
          if (step != '0) step_nxt = step - SW'(1);
          if (step <= SW'(1)) state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // Drive ctrl straight from the next step so it is a thermometer code by
    // construction: bits [step-1:0] set, everything above clear.
    ctrl_nxt = '0;
    for (int i = 0; i < NCTRL; i++) begin
      ctrl_nxt[i] = (SW'(i) < step_nxt);
    end
    busy_nxt  = (state_nxt == ST_UP) || (state_nxt == ST_DOWN);
    ready_nxt = (state_nxt == ST_READY);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      step  <= '0;
      ctrl  <= '0;
      ready <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      step  <= step_nxt;
      ctrl  <= ctrl_nxt;
      ready <= ready_nxt;
      busy  <= busy_nxt;
    end
  end

endmodule
